// File: rtl/cmult_stream.sv
// cmult_stream: streaming fixed-point complex multiplier, p = a*b or a*conj(b).
//
// Four register stages (operands -> partial products -> rounded sums ->
// scaled/range-checked outputs) advance together under a single ready/valid
// handshake. Bubbles flow through as valid=0. Output fields hold their last
// value while out_valid is 0.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !(out_valid & !out_ready)
//   in_conj, in_tag     per-sample conjugate select and sideband tag
//   ar, ai, br, bi      signed N-bit operand components, Q fractional bits
//   out_valid/out_ready output handshake
//   pr, pi, out_tag     result components and the matching tag
//   out_ovr             result left the N-bit range in pr or pi
//   clr_ovr, ovr_cnt    synchronous clear / saturating count of overflowed results
//
// Build option: define CMULT_STREAM_SAT_EN to saturate out-of-range components;
// otherwise they wrap to the low N bits of the scaled value.

module cmult_stream #(
   parameter int Q  = 8,
   parameter int N  = 16,
   parameter int TW = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_conj,
   input  logic [TW-1:0]       in_tag,
   input  logic signed [N-1:0] ar,
   input  logic signed [N-1:0] ai,
   input  logic signed [N-1:0] br,
   input  logic signed [N-1:0] bi,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] pr,
   output logic signed [N-1:0] pi,
   output logic [TW-1:0]       out_tag,
   output logic                out_ovr,
   input  logic                clr_ovr,
   output logic [15:0]         ovr_cnt
);

   // Full-precision width: N x (N+1) products summed without loss.
   localparam int W = 2*N + 2;
   localparam logic signed [W-1:0] RND = {{(W-1){1'b0}}, 1'b1} << (Q-1);

   // True when the scaled value is representable in N signed bits.
   function automatic logic fits_n(input logic signed [W-1:0] v);
      return (&v[W-1:N-1]) | ~(|v[W-1:N-1]);
   endfunction

   // Reduce a scaled value to N bits, saturating or wrapping.
   function automatic logic [N-1:0] reduce_n(input logic signed [W-1:0] v);
`ifdef CMULT_STREAM_SAT_EN
      if (fits_n(v)) begin
         return v[N-1:0];
      end else if (v[W-1]) begin
         return {1'b1, {(N-1){1'b0}}};
      end else begin
         return {1'b0, {(N-1){1'b1}}};
      end
`else
      return v[N-1:0];
`endif
   endfunction

   logic                adv_s;
   logic                v1_r, v2_r, v3_r;
   logic signed [N-1:0] ar1_r, ai1_r, br1_r, bi1_r;
   logic                conj1_r;
   logic [TW-1:0]       tag1_r, tag2_r, tag3_r;
   logic signed [N:0]   bi_ext_s, bin_s;
   logic signed [W-1:0] ar_w_s, ai_w_s, br_w_s, bin_w_s;
   logic signed [W-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
   logic signed [W-1:0] sr_r, si_r;
   logic signed [W-1:0] shr_s, shi_s;

   // Whole pipeline moves unless a result is waiting on downstream.
   assign adv_s    = !(out_valid && !out_ready);
   assign in_ready = adv_s;

   // Conjugate select: negate bi at N+1 bits so -2^(N-1) stays exact, then sign-extend.
   always_comb begin
      bi_ext_s = {bi1_r[N-1], bi1_r};
      if (conj1_r) begin
         bin_s = -bi_ext_s;
      end else begin
         bin_s = bi_ext_s;
      end
      ar_w_s  = {{(W-N){ar1_r[N-1]}}, ar1_r};
      ai_w_s  = {{(W-N){ai1_r[N-1]}}, ai1_r};
      br_w_s  = {{(W-N){br1_r[N-1]}}, br1_r};
      bin_w_s = {{(W-N-1){bin_s[N]}}, bin_s};
      shr_s   = sr_r >>> Q;
      shi_s   = si_r >>> Q;
   end

   // Pipeline stages S1..S4 plus output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
         ar1_r <= '0; ai1_r <= '0; br1_r <= '0; bi1_r <= '0;
         conj1_r <= 1'b0;
         tag1_r <= '0; tag2_r <= '0; tag3_r <= '0;
         p_rr_r <= '0; p_ii_r <= '0; p_ri_r <= '0; p_ir_r <= '0;
         sr_r <= '0; si_r <= '0;
         out_valid <= 1'b0;
         pr <= '0; pi <= '0; out_tag <= '0; out_ovr <= 1'b0;
      end else if (adv_s) begin
         v1_r    <= in_valid;
         ar1_r   <= ar;
         ai1_r   <= ai;
         br1_r   <= br;
         bi1_r   <= bi;
         conj1_r <= in_conj;
         tag1_r  <= in_tag;

         v2_r   <= v1_r;
         tag2_r <= tag1_r;
         p_rr_r <= ar_w_s * br_w_s;
         p_ii_r <= ai_w_s * bin_w_s;
         p_ri_r <= ar_w_s * bin_w_s;
         p_ir_r <= ai_w_s * br_w_s;

         v3_r   <= v2_r;
         tag3_r <= tag2_r;
         sr_r   <= p_rr_r - p_ii_r + RND;
         si_r   <= p_ri_r + p_ir_r + RND;

         out_valid <= v3_r;
         // Output fields only change when a real sample lands, so they hold across bubbles.
         if (v3_r) begin
            pr      <= reduce_n(shr_s);
            pi      <= reduce_n(shi_s);
            out_tag <= tag3_r;
            out_ovr <= !(fits_n(shr_s) && fits_n(shi_s));
         end
      end
   end

   // Saturating count of delivered overflowed results; clear has priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr_cnt <= 16'h0000;
      end else if (clr_ovr) begin
         ovr_cnt <= 16'h0000;
      end else if (out_valid && out_ready && out_ovr && (ovr_cnt != 16'hFFFF)) begin
         ovr_cnt <= ovr_cnt + 16'h0001;
      end
   end

endmodule

// File: doc/cmult_stream.md
CMULT_STREAM -- requirements
Module: cmult_stream

Interface
REQ-001 SHALL have parameter Q, default 8: fractional bits of all fixed-point operands and results.
REQ-002 SHALL have parameter N, default 16: total bits per real/imag component, two's complement.
REQ-003 SHALL have parameter TW, default 4: width of the sideband tag carried alongside each sample.
REQ-004 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts the input sample this cycle.
- in_conj  in  1  multiply by conj(b) instead of b for this sample.
- in_tag  in  TW  sideband tag, passed through unchanged.
- ar, ai, br, bi  in  N each  signed operands a = ar + j*ai, b = br + j*bi.
- out_valid  out  1  result sample present.
- out_ready  in  1  downstream accepts the result this cycle.
- pr, pi  out  N each  signed result components.
- out_tag  out  TW  tag of this result.
- out_ovr  out  1  this result overflowed in pr or pi.
- clr_ovr  in  1  synchronous clear of ovr_cnt.
- ovr_cnt  out  16  count of overflowed results delivered.

Function
REQ-005 The block SHALL compute p = a*b, or p = a*conj(b) when in_conj=1: pr = ar*br - ai*bi', pi = ar*bi' + ai*br, with bi' = -bi when conjugating.
REQ-006 The negation of bi SHALL be done at N+1 bits, so bi = -2^(N-1) negates exactly.
REQ-007 Products and sums SHALL be kept at full precision (2N+2 bits); no intermediate truncation.
REQ-008 Scaling SHALL add 2^(Q-1), then arithmetic-shift right by Q (round half toward +inf).
REQ-009 out_ovr SHALL be 1 when either scaled component lies outside [-2^(N-1), 2^(N-1)-1].
REQ-010 The pipeline SHALL be 4 register stages:
- S1: operands, conj, tag.
- S2: four partial products.
- S3: sum/difference plus rounding constant.
- S4: shift, range check and output registers.
REQ-011 Latency SHALL be exactly 4 cycles from an accepted input (in_valid & in_ready) to out_valid when out_ready stays 1.
REQ-012 Stall: the pipeline SHALL advance all stages only when !(out_valid & !out_ready); in_ready SHALL equal that condition.
REQ-013 While stalled, all stage contents and outputs SHALL hold; there is no loss, duplication or reordering.
REQ-014 Bubbles (in_valid=0 when accepted) SHALL propagate as valid=0 and SHALL be collapsed only by normal advance.
REQ-015 A full pipeline with out_ready=1 SHALL sustain one result per cycle.
REQ-016 ovr_cnt SHALL increment by 1 on each transfer (out_valid & out_ready & out_ovr), and SHALL saturate at 0xFFFF.
REQ-017 If clr_ovr and an incrementing transfer coincide, clr_ovr SHALL win and ovr_cnt SHALL become 0.
REQ-018 pr, pi, out_tag and out_ovr SHALL be don't-care-free: they SHALL be held at the last value when out_valid=0.

Reset
REQ-019 Asserting rst low SHALL immediately clear every stage valid bit, out_valid, out_ovr, ovr_cnt, pr, pi and out_tag to 0, including mid-operation.
REQ-020 After reset, in_ready SHALL be 1, and the first accepted sample SHALL appear 4 cycles later.

Configuration
REQ-021 Macro CMULT_STREAM_SAT_EN, when defined: an out-of-range component SHALL saturate to 2^(N-1)-1 or -2^(N-1).
REQ-022 Without CMULT_STREAM_SAT_EN: an out-of-range component SHALL wrap, taking the low N bits of the shifted value.
REQ-023 out_ovr and ovr_cnt SHALL behave identically in both builds.

Verification (Q=8, N=16)
REQ-024 Directed scenarios the bench SHALL cover:
- Basic: ar=ai=br=bi=0x0100, in_conj=0, out_ready=1 -> 4 cycles later pr=0x0000, pi=0x0200, out_ovr=0.
- Conjugate: same operands, in_conj=1, tag=0x5 -> pr=0x0200, pi=0x0000, out_tag=0x5.
- Overflow: ar=br=0x7FFF, ai=bi=0 -> out_ovr=1 and ovr_cnt=1.
  - With CMULT_STREAM_SAT_EN: pr=0x7FFF.
  - Without it: pr=0xFF00.
- Rounding: ar=0x0001, br=0x0080, ai=bi=0 -> pr=0x0001; ar=0xFFFF, br=0x0080 -> pr=0x0000.
- Back-pressure: 6 back-to-back samples with tags 0..5, out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, all 6 results delivered once, in tag order.
- Reset mid-stream: rst low with 3 samples in flight -> out_valid=0 and ovr_cnt=0 immediately; no stale results after release.
